// File: rtl/opcode_pkg.sv
// Shared opcode encoding plus the issue controller's state type and defaults.
package opcode_pkg;

  // 4-bit ALU opcode as produced by the decoder and consumed by the ALU.
  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_XOR   = 4'h5,
    OP_SLL   = 4'h6,
    OP_SRL   = 4'h7,
    OP_SRA   = 4'h8,
    OP_SLT   = 4'h9,
    OP_SLTU  = 4'hA,
    OP_MUL   = 4'hB,
    OP_MULH  = 4'hC,
    OP_PASSB = 4'hD,
    OP_RES1  = 4'hE,
    OP_RES2  = 4'hF
  } opcode_t;

  // Issue/writeback controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } alu_ctrl_state_t;

  localparam int ALU_CTRL_TIMEOUT_DEF = 8;

endpackage

// File: rtl/alu_op_class.sv
// Classifies an opcode into the three ways the issue controller treats it.
module alu_op_class
  import opcode_pkg::*;
(
  input  opcode_t op,
  output logic    is_nop,
  output logic    is_reserved,
  output logic    is_exec
);

  // Exactly one class is active for every encoding.
  always_comb begin
    is_nop      = (op == OP_NOP);
    is_reserved = (op == OP_RES1) || (op == OP_RES2);
    is_exec     = !is_nop && !is_reserved;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded instruction at a time to the combinational ALU:
// read sources, execute (bounded wait on alu_done), write back, retire.
module alu_issue_ctrl
  import opcode_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter int TIMEOUT = ALU_CTRL_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  opcode_t           instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  output logic [REG_AW-1:0] rf_raddr_a,
  output logic [REG_AW-1:0] rf_raddr_b,
  input  logic [31:0]       rf_rdata_a,
  input  logic [31:0]       rf_rdata_b,
  output opcode_t           alu_op,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [31:0]       alu_result,
  input  logic              alu_done,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              busy,
  output logic              err_illegal,
  output logic              err_timeout,
  output logic [15:0]       retire_cnt
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  alu_ctrl_state_t   state, state_nxt;
  opcode_t           op_q;
  logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
  logic [31:0]       opa_q, opb_q, res_q;
  logic [7:0]        tcnt_q;
  logic              ready_q;
  logic              err_illegal_q, err_timeout_q;
  logic [15:0]       retire_q;

  logic is_nop, is_reserved, is_exec;
  logic fire, timeout_hit;

  alu_op_class u_op_class (
    .op          (instr_op),
    .is_nop      (is_nop),
    .is_reserved (is_reserved),
    .is_exec     (is_exec)
  );

  assign fire        = instr_valid && instr_ready;
  assign timeout_hit = (state == EXEC) && !alu_done && (tcnt_q == TIMEOUT_LAST);

  // Next-state logic for the READ -> EXEC -> WB sequence.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (fire && is_exec) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC: begin
        if (alu_done)         state_nxt = WB;
        else if (timeout_hit) state_nxt = IDLE;
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Instruction latch, operand/result registers, counters and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q       <= 1'b0;
      op_q          <= OP_NOP;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      res_q         <= '0;
      tcnt_q        <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
      retire_q      <= '0;
    end else begin
      // Ready is registered so it is low while rst is applied and rises
      // together with the return to IDLE.
      ready_q       <= (state_nxt == IDLE);
      err_illegal_q <= fire && is_reserved;
      err_timeout_q <= timeout_hit;

      if (fire) begin
        op_q  <= instr_op;
        rd_q  <= instr_rd;
        rs1_q <= instr_rs1;
        rs2_q <= instr_rs2;
      end

      if (state == READ) begin
        opa_q  <= rf_rdata_a;
        opb_q  <= rf_rdata_b;
        tcnt_q <= '0;
      end

      if (state == EXEC) begin
        if (alu_done) res_q  <= alu_result;
        else          tcnt_q <= tcnt_q + 8'd1;
      end

      if ((fire && is_nop) || (state == WB))
        retire_q <= retire_q + 16'd1;
    end
  end

  // Read addresses and operands are held from their registers in every
  // state; only the op is gated so the ALU idles at NOP outside EXEC.
  assign instr_ready = ready_q && !rst;
  assign rf_raddr_a  = rs1_q;
  assign rf_raddr_b  = rs2_q;
  assign alu_op      = (state == EXEC) ? op_q : OP_NOP;
  assign alu_a       = opa_q;
  assign alu_b       = opb_q;
  assign rf_we       = (state == WB) && !rst;
  assign rf_waddr    = rd_q;
  assign rf_wdata    = res_q;
  assign busy        = (state != IDLE);
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;
  assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a register-file and ALU model.
module tb_alu_issue_ctrl;
  import opcode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  opcode_t     instr_op;
  logic [3:0]  instr_rd, instr_rs1, instr_rs2;
  logic [3:0]  rf_raddr_a, rf_raddr_b;
  logic [31:0] rf_rdata_a, rf_rdata_b;
  opcode_t     alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_done;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy, err_illegal, err_timeout;
  logic [15:0] retire_cnt;

  logic        stall;
  logic [31:0] rf_mem [16];

  int n_vec = 0;
  int n_err = 0;
  int we_seen = 0;
  int ill_seen = 0;
  int tmo_seen = 0;
  logic [15:0] exp_retire;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.REG_AW(4), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs1   (instr_rs1),
    .instr_rs2   (instr_rs2),
    .rf_raddr_a  (rf_raddr_a),
    .rf_raddr_b  (rf_raddr_b),
    .rf_rdata_a  (rf_rdata_a),
    .rf_rdata_b  (rf_rdata_b),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_done    (alu_done),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy        (busy),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout),
    .retire_cnt  (retire_cnt)
  );

  // Register file read data for the address held through READ.
  assign rf_rdata_a = rf_mem[rf_raddr_a];
  assign rf_rdata_b = rf_mem[rf_raddr_b];

  // Combinational ALU model; stall withholds alu_done.
  function automatic logic [31:0] alu_model(opcode_t op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    case (op)
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_XOR:   return a ^ b;
      OP_SLL:   return a << b[4:0];
      OP_SRL:   return a >> b[4:0];
      OP_SRA:   return 32'($signed(a) >>> b[4:0]);
      OP_SLT:   return {31'd0, $signed(a) < $signed(b)};
      OP_SLTU:  return {31'd0, a < b};
      OP_MUL:   return a * b;
      OP_MULH: begin
        p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        return p[63:32];
      end
      OP_PASSB: return b;
      default:  return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_model(alu_op, alu_a, alu_b);
  assign alu_done   = !stall;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (rf_we)       we_seen++;
    if (err_illegal) ill_seen++;
    if (err_timeout) tmo_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive an instruction, wait (bounded) for ready, return just after the accept edge.
  task automatic issue(input opcode_t op, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2);
    int w;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rd    = rd;
    instr_rs1   = rs1;
    instr_rs2   = rs2;
    w = 0;
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready) check("ready_wait", 32'(instr_ready), 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  typedef struct {
    opcode_t     op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int we0, tmo0, ill0;

    vecs[0]  = '{OP_ADD,   4'd3,  4'd1,  4'd2,  32'd5,         32'd7,         32'd12};
    vecs[1]  = '{OP_SUB,   4'd4,  4'd5,  4'd6,  32'd10,        32'd3,         32'd7};
    vecs[2]  = '{OP_SUB,   4'd9,  4'd1,  4'd2,  32'd0,         32'd1,         32'hFFFF_FFFF};
    vecs[3]  = '{OP_AND,   4'd1,  4'd7,  4'd8,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[4]  = '{OP_OR,    4'd2,  4'd3,  4'd4,  32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0};
    vecs[5]  = '{OP_XOR,   4'd5,  4'd10, 4'd11, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00};
    vecs[6]  = '{OP_SLL,   4'd6,  4'd12, 4'd13, 32'd1,         32'd31,        32'h8000_0000};
    vecs[7]  = '{OP_SRL,   4'd7,  4'd14, 4'd15, 32'h8000_0000, 32'd4,         32'h0800_0000};
    vecs[8]  = '{OP_SRA,   4'd8,  4'd14, 4'd15, 32'h8000_0000, 32'd4,         32'hF800_0000};
    vecs[9]  = '{OP_SLT,   4'd10, 4'd1,  4'd2,  32'hFFFF_FFFF, 32'd1,         32'd1};
    vecs[10] = '{OP_SLTU,  4'd11, 4'd1,  4'd2,  32'hFFFF_FFFF, 32'd1,         32'd0};
    vecs[11] = '{OP_MUL,   4'd12, 4'd3,  4'd4,  32'd3,         32'd7,         32'd21};
    vecs[12] = '{OP_MULH,  4'd13, 4'd5,  4'd6,  32'h0001_0000, 32'h0001_0000, 32'd1};
    vecs[13] = '{OP_PASSB, 4'd14, 4'd7,  4'd8,  32'h1234_5678, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[14] = '{OP_ADD,   4'd0,  4'd9,  4'd10, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000};

    for (int i = 0; i < 16; i++) rf_mem[i] = 32'd0;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr_op    = OP_NOP;
    instr_rd    = '0;
    instr_rs1   = '0;
    instr_rs2   = '0;
    stall       = 1'b0;
    exp_retire  = 16'd0;

    // Reset state while rst is held, then idle after release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",   32'(instr_ready), 32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_alu_op",  32'(alu_op),      32'(OP_NOP));
    check("rst_alu_a",   alu_a,            32'd0);
    check("rst_retire",  32'(retire_cnt),  32'd0);
    check("rst_rf_we",   32'(rf_we),       32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready",  32'(instr_ready), 32'd1);
    check("idle_alu_op", 32'(alu_op),      32'(OP_NOP));
    repeat (3) @(negedge clk);
    check("idle_no_we",  32'(we_seen),     32'd0);

    // Table-driven ALU instructions with the full 4-cycle sequence.
    for (int i = 0; i < 15; i++) begin
      rf_mem[vecs[i].rs1] = vecs[i].a;
      rf_mem[vecs[i].rs2] = vecs[i].b;
      issue(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
      @(negedge clk);  // N+1 READ
      check("read_busy",   32'(busy),        32'd1);
      check("read_ready",  32'(instr_ready), 32'd0);
      check("read_raddr",  32'(rf_raddr_a),  32'(vecs[i].rs1));
      @(negedge clk);  // N+2 EXEC
      check("exec_op",     32'(alu_op),      32'(vecs[i].op));
      check("exec_a",      alu_a,            vecs[i].a);
      check("exec_b",      alu_b,            vecs[i].b);
      @(negedge clk);  // N+3 WB
      check("wb_we",       32'(rf_we),       32'd1);
      check("wb_waddr",    32'(rf_waddr),    32'(vecs[i].rd));
      check("wb_wdata",    rf_wdata,         vecs[i].exp);
      exp_retire = exp_retire + 16'd1;
      @(negedge clk);  // N+4 ready again
      check("done_ready",  32'(instr_ready), 32'd1);
      check("done_we",     32'(rf_we),       32'd0);
      check("done_retire", 32'(retire_cnt),  32'(exp_retire));
    end

    // Back-to-back NOP, RES1, MUL on consecutive cycles.
    rf_mem[8] = 32'h0001_0000;
    rf_mem[9] = 32'h0001_0000;
    ill0 = ill_seen;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op = OP_NOP;  instr_rd = 4'd0; instr_rs1 = 4'd0; instr_rs2 = 4'd0;
    @(negedge clk);
    check("b2b_nop_retire", 32'(retire_cnt),  32'(exp_retire + 16'd1));
    check("b2b_nop_ready",  32'(instr_ready), 32'd1);
    instr_op = OP_RES1;
    @(negedge clk);
    check("b2b_illegal",    32'(err_illegal), 32'd1);
    check("b2b_res_retire", 32'(retire_cnt),  32'(exp_retire + 16'd1));
    instr_op = OP_MUL;  instr_rd = 4'd5; instr_rs1 = 4'd8; instr_rs2 = 4'd9;
    @(negedge clk);
    instr_valid = 1'b0;
    check("b2b_illegal_off", 32'(err_illegal), 32'd0);
    check("b2b_mul_busy",    32'(busy),        32'd1);
    @(negedge clk);
    @(negedge clk);
    check("b2b_mul_we",    32'(rf_we),    32'd1);
    check("b2b_mul_waddr", 32'(rf_waddr), 32'd5);
    check("b2b_mul_wdata", rf_wdata,      32'h0000_0000);
    exp_retire = exp_retire + 16'd2;
    @(negedge clk);
    check("b2b_retire",    32'(retire_cnt),      32'(exp_retire));
    check("b2b_ill_count", 32'(ill_seen - ill0), 32'd1);

    // Timeout: alu_done withheld, TIMEOUT=4.
    stall = 1'b1;
    we0  = we_seen;
    tmo0 = tmo_seen;
    issue(OP_ADD, 4'd7, 4'd1, 4'd2);
    @(negedge clk);                    // N+1 READ
    repeat (4) @(negedge clk);         // N+2..N+5 EXEC
    check("tmo_still_exec", 32'(busy),        32'd1);
    check("tmo_not_yet",    32'(err_timeout), 32'd0);
    @(negedge clk);                    // N+6
    check("tmo_pulse",      32'(err_timeout), 32'd1);
    check("tmo_idle",       32'(busy),        32'd0);
    check("tmo_ready",      32'(instr_ready), 32'd1);
    @(negedge clk);                    // N+7
    check("tmo_pulse_off",  32'(err_timeout), 32'd0);
    check("tmo_ready_next", 32'(instr_ready), 32'd1);
    check("tmo_no_we",      32'(we_seen - we0),   32'd0);
    check("tmo_count",      32'(tmo_seen - tmo0), 32'd1);
    check("tmo_retire",     32'(retire_cnt),  32'(exp_retire));
    stall = 1'b0;

    // Reset asserted during EXEC of a SUB.
    rf_mem[1] = 32'd9;
    rf_mem[2] = 32'd4;
    we0 = we_seen;
    issue(OP_SUB, 4'd6, 4'd1, 4'd2);
    @(negedge clk);                    // READ
    @(negedge clk);                    // EXEC
    check("mid_exec_op", 32'(alu_op), 32'(OP_SUB));
    rst = 1'b1;
    @(negedge clk);
    check("mid_busy",    32'(busy),        32'd0);
    check("mid_ready",   32'(instr_ready), 32'd0);
    check("mid_alu_op",  32'(alu_op),      32'(OP_NOP));
    check("mid_alu_a",   alu_a,            32'd0);
    check("mid_alu_b",   alu_b,            32'd0);
    check("mid_raddr",   32'({rf_raddr_a, rf_raddr_b}), 32'd0);
    check("mid_waddr",   32'(rf_waddr),    32'd0);
    check("mid_wdata",   rf_wdata,         32'd0);
    check("mid_errs",    32'({err_illegal, err_timeout}), 32'd0);
    check("mid_retire",  32'(retire_cnt),  32'd0);
    rst = 1'b0;
    exp_retire = 16'd0;
    repeat (4) @(negedge clk);
    check("mid_no_we",   32'(we_seen - we0), 32'd0);
    check("mid_ready_after", 32'(instr_ready), 32'd1);

    // Retire counter wrap via back-to-back NOPs.
    we0 = we_seen;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = OP_NOP;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    check("wrap_ffff", 32'(retire_cnt), 32'h0000_FFFF);
    issue(OP_NOP, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    check("wrap_zero",  32'(retire_cnt),     32'd0);
    check("wrap_no_we", 32'(we_seen - we0),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
